// File: rtl/ysyx_22050078_wbu_if.sv
// Write-back unit bus: issue reservation, operand busy lookup,
// ALU/LSU result channels and the register-file write port.
interface ysyx_22050078_wbu_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
);
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  issue_ready;

    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [2:0]            lsu_funct3;
    logic [2:0]            lsu_off;
    logic [DATA_WIDTH-1:0] lsu_rdata;

    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    modport slave (
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_funct3, lsu_off, lsu_rdata,
        output issue_ready, rs1_busy, rs2_busy,
        output alu_ready, lsu_ready, wen, waddr, wdata
    );

    modport master (
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_funct3, lsu_off, lsu_rdata,
        input  issue_ready, rs1_busy, rs2_busy,
        input  alu_ready, lsu_ready, wen, waddr, wdata
    );
endinterface

// File: rtl/ysyx_22050078_wbu.sv
// Write-back unit: arbitrates ALU/LSU results into one registered
// regfile write and tracks pending destinations in a busy scoreboard.
module ysyx_22050078_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    ysyx_22050078_wbu_if.slave   bus
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int DW   = DATA_WIDTH;

    logic [NREG-1:0]       busy_q, busy_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [DW-1:0]         sh;
    logic [DW-1:0]         ld_data;
    logic                  lsu_fire, alu_fire, issue_fire;

    assign bus.lsu_ready   = 1'b1;
    assign bus.alu_ready   = ~bus.lsu_valid;
    assign lsu_fire        = bus.lsu_valid;
    assign alu_fire        = bus.alu_valid & ~bus.lsu_valid;

    assign bus.issue_ready = ~busy_q[bus.issue_rd];
    assign issue_fire      = bus.issue_valid & bus.issue_ready
                           & (bus.issue_rd != '0);

    assign bus.rs1_busy    = busy_q[bus.rs1_addr];
    assign bus.rs2_busy    = busy_q[bus.rs2_addr];

    assign bus.wen         = wen_q;
    assign bus.waddr       = waddr_q;
    assign bus.wdata       = wdata_q;

    assign sh = bus.lsu_rdata >> {bus.lsu_off, 3'b000};

    // Misaligned offsets and the reserved funct3 fall through to zero.
    always_comb begin
        ld_data = '0;
        unique case (bus.lsu_funct3)
            3'b000: ld_data = {{(DW-8){sh[7]}}, sh[7:0]};
            3'b001: if (!bus.lsu_off[0])
                ld_data = {{(DW-16){sh[15]}}, sh[15:0]};
            3'b010: if (bus.lsu_off[1:0] == 2'b00)
                ld_data = {{(DW-32){sh[31]}}, sh[31:0]};
            3'b011: if (bus.lsu_off == 3'b000)
                ld_data = sh;
            3'b100: ld_data = {{(DW-8){1'b0}}, sh[7:0]};
            3'b101: if (!bus.lsu_off[0])
                ld_data = {{(DW-16){1'b0}}, sh[15:0]};
            3'b110: if (bus.lsu_off[1:0] == 2'b00)
                ld_data = {{(DW-32){1'b0}}, sh[31:0]};
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (lsu_fire) begin
            wen_d   = bus.lsu_rd != '0;
            waddr_d = bus.lsu_rd;
            wdata_d = ld_data;
        end else if (alu_fire) begin
            wen_d   = bus.alu_rd != '0;
            waddr_d = bus.alu_rd;
            wdata_d = bus.alu_data;
        end
    end

    // Clear before set so a same-edge reserve of the committing index wins.
    always_comb begin
        busy_d = busy_q;
        if (wen_q)
            busy_d[waddr_q] = 1'b0;
        if (issue_fire)
            busy_d[bus.issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22050078_wbu.sv
// Directed plus random bench for the write-back unit, with an
// expected-write queue and a reference busy/load model.
module tb_ysyx_22050078_wbu;
    typedef struct {
        logic        wen;
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    exp_t       q[$];
    logic [31:0] m_busy = '0;
    logic        m_wen = 1'b0;
    logic [4:0]  m_waddr = '0;

    always #5 clk = ~clk;

    ysyx_22050078_wbu_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();

    ysyx_22050078_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mload(input logic [2:0] f,
                                          input logic [2:0] off,
                                          input logic [63:0] rd);
        int sz;
        int o;
        logic [63:0] v;
        sz = 1 << f[1:0];
        o  = int'(off);
        if (f == 3'b111 || (o % sz) != 0) return 64'h0;
        v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(o+i) +: 8];
        if (!f[2] && sz < 8 && v[8*sz-1])
            for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.lsu_valid   = 1'b0;
    endtask

    task automatic step();
        exp_t e;
        logic isf;
        #1;
        chk("alu_ready", {63'b0, bus.alu_ready}, {63'b0, !bus.lsu_valid});
        chk("lsu_ready", {63'b0, bus.lsu_ready}, 64'd1);
        chk("issue_ready", {63'b0, bus.issue_ready},
            {63'b0, !m_busy[bus.issue_rd]});
        chk("rs1_busy", {63'b0, bus.rs1_busy}, {63'b0, m_busy[bus.rs1_addr]});
        chk("rs2_busy", {63'b0, bus.rs2_busy}, {63'b0, m_busy[bus.rs2_addr]});
        isf = bus.issue_valid && !m_busy[bus.issue_rd] && bus.issue_rd != 0;
        e.wen = 1'b0; e.addr = '0; e.data = '0;
        if (bus.lsu_valid) begin
            e.wen  = bus.lsu_rd != 0;
            e.addr = bus.lsu_rd;
            e.data = mload(bus.lsu_funct3, bus.lsu_off, bus.lsu_rdata);
        end else if (bus.alu_valid) begin
            e.wen  = bus.alu_rd != 0;
            e.addr = bus.alu_rd;
            e.data = bus.alu_data;
        end
        q.push_back(e);
        @(posedge clk);
        if (m_wen) m_busy[m_waddr] = 1'b0;
        if (isf) m_busy[bus.issue_rd] = 1'b1;
        m_wen = e.wen;
        m_waddr = e.addr;
        #1;
        e = q.pop_front();
        chk("wen", {63'b0, bus.wen}, {63'b0, e.wen});
        if (e.wen) begin
            chk("waddr", {59'b0, bus.waddr}, {59'b0, e.addr});
            chk("wdata", bus.wdata, e.data);
        end
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f,
                        input logic [2:0] off, input logic [63:0] d);
        idle();
        bus.lsu_valid = 1'b1; bus.lsu_rd = rd;
        bus.lsu_funct3 = f; bus.lsu_off = off; bus.lsu_rdata = d;
        step();
    endtask

    initial begin
        idle();
        bus.issue_rd = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;
        bus.alu_rd = '0; bus.alu_data = '0;
        bus.lsu_rd = '0; bus.lsu_funct3 = '0; bus.lsu_off = '0;
        bus.lsu_rdata = '0;
        bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd9; bus.issue_rd = 5'd5;
        #3;
        chk("rst_wen", {63'b0, bus.wen}, 64'd0);
        chk("rst_waddr", {59'b0, bus.waddr}, 64'd0);
        chk("rst_wdata", bus.wdata, 64'd0);
        chk("rst_issue_ready", {63'b0, bus.issue_ready}, 64'd1);
        chk("rst_rs1_busy", {63'b0, bus.rs1_busy}, 64'd0);
        chk("rst_rs2_busy", {63'b0, bus.rs2_busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reserve x5 on the first edge, then retire it from the ALU.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        step();
        chk("x5_busy", {63'b0, bus.rs1_busy}, 64'd1);
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h1234;
        step();
        chk("x5_wdata", bus.wdata, 64'h1234);
        chk("x5_busy_commit", {63'b0, bus.rs1_busy}, 64'd1);
        idle();
        step();
        chk("x5_free", {63'b0, bus.rs1_busy}, 64'd0);

        // LSU wins over ALU; ALU retries next cycle.
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_funct3 = 3'b011;
        bus.lsu_off = 3'd0; bus.lsu_rdata = 64'h0123_4567_89AB_CDEF;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 64'h44;
        step();
        chk("prio_first", {59'b0, bus.waddr}, 64'd3);
        bus.lsu_valid = 1'b0;
        step();
        chk("prio_second", {59'b0, bus.waddr}, 64'd4);

        load(5'd1, 3'b000, 3'd7, 64'h8011_2233_4455_6677);
        chk("lb_sext", bus.wdata, 64'hFFFF_FFFF_FFFF_FF80);
        load(5'd2, 3'b101, 3'd2, 64'h0000_0000_BEEF_0000);
        chk("lhu", bus.wdata, 64'h0000_0000_0000_BEEF);
        load(5'd3, 3'b110, 3'd4, 64'hDEAD_BEEF_0000_0000);
        chk("lwu", bus.wdata, 64'h0000_0000_DEAD_BEEF);
        load(5'd4, 3'b010, 3'd4, 64'hDEAD_BEEF_0000_0000);
        chk("lw_sext", bus.wdata, 64'hFFFF_FFFF_DEAD_BEEF);
        load(5'd5, 3'b001, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("lh_misalign", bus.wdata, 64'h0);
        load(5'd6, 3'b111, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("f3_111", bus.wdata, 64'h0);
        load(5'd7, 3'b011, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ld_misalign", bus.wdata, 64'h0);

        // Unreserved x7 write; reserve x7 in its commit cycle.
        idle();
        bus.rs1_addr = 5'd7;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 64'h77;
        step();
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        step();
        chk("x7_set_wins", {63'b0, bus.rs1_busy}, 64'd1);
        step();
        chk("x7_not_ready", {63'b0, bus.issue_ready}, 64'd0);

        // x0 result handshakes but never writes.
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 64'hFF;
        step();
        chk("x0_no_wen", {63'b0, bus.wen}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            bus.issue_valid = 1'($urandom_range(0, 1));
            bus.issue_rd    = 5'($urandom);
            bus.rs1_addr    = 5'($urandom);
            bus.rs2_addr    = 5'($urandom);
            bus.alu_valid   = 1'($urandom_range(0, 1));
            bus.alu_rd      = 5'($urandom);
            bus.alu_data    = {$urandom, $urandom};
            bus.lsu_valid   = ($urandom_range(0, 3) == 0);
            bus.lsu_rd      = 5'($urandom);
            bus.lsu_funct3  = 3'($urandom);
            bus.lsu_off     = 3'($urandom);
            bus.lsu_rdata   = {$urandom, $urandom};
            step();
        end

        // Reset with x9 reserved and a write to x9 staged.
        idle();
        bus.rs1_addr = 5'd9; bus.issue_rd = 5'd9;
        if (m_busy[9]) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd9;
            step();
            idle();
            step();
        end
        bus.issue_valid = 1'b1;
        step();
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 64'h99;
        step();
        chk("pre_rst_busy9", {63'b0, bus.rs1_busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_wen", {63'b0, bus.wen}, 64'd0);
        chk("arst_wdata", bus.wdata, 64'd0);
        chk("arst_busy9", {63'b0, bus.rs1_busy}, 64'd0);
        chk("arst_issue_ready", {63'b0, bus.issue_ready}, 64'd1);
        m_busy = '0; m_wen = 1'b0; m_waddr = '0;
        q.delete();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_no_wen", {63'b0, bus.wen}, 64'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
